// File: rtl/cpu7_lsu_ctl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu7_lsu_ctl_pkg : LSU op encodings, bus size codes and FSM states    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu7_lsu_ctl_pkg;

    localparam int LSU_OP_W = 4;

    localparam logic [LSU_OP_W-1:0] LSU_LB  = 4'd0;
    localparam logic [LSU_OP_W-1:0] LSU_LH  = 4'd1;
    localparam logic [LSU_OP_W-1:0] LSU_LW  = 4'd2;
    localparam logic [LSU_OP_W-1:0] LSU_LBU = 4'd4;
    localparam logic [LSU_OP_W-1:0] LSU_LHU = 4'd5;
    localparam logic [LSU_OP_W-1:0] LSU_SB  = 4'd8;
    localparam logic [LSU_OP_W-1:0] LSU_SH  = 4'd9;
    localparam logic [LSU_OP_W-1:0] LSU_SW  = 4'd10;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Undefined op codes fall through to word-sized loads.
    function automatic logic [1:0] lsu_size(input logic [LSU_OP_W-1:0] op);
        logic [1:0] size;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: size = SIZE_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: size = SIZE_HALF;
            default:                 size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic lsu_is_store(input logic [LSU_OP_W-1:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_is_signed(input logic [LSU_OP_W-1:0] op);
        return (op == LSU_LB) || (op == LSU_LH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu7_lsu_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu7_lsu_align : byte-lane steering for stores, load extraction and   |
// |                  misalignment detection (purely combinational)         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu7_lsu_align
    import cpu7_lsu_ctl_pkg::*;
#(
    parameter int GRLEN        = 32,
    parameter int LSU_CODE_BIT = 4
) (
    input  logic [LSU_CODE_BIT-1:0] op,
    input  logic [1:0]              addr_lo,
    input  logic [GRLEN-1:0]        store_data,
    input  logic [GRLEN-1:0]        load_data,
    output logic [1:0]              size,
    output logic                    is_store,
    output logic                    misalign,
    output logic [3:0]              wstrb,
    output logic [GRLEN-1:0]        wdata,
    output logic [GRLEN-1:0]        load_result
);

    logic       w_sext;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    assign size     = lsu_size(op);
    assign is_store = lsu_is_store(op);
    assign w_sext   = lsu_is_signed(op);

    assign misalign = ((size == SIZE_HALF) && addr_lo[0]) ||
                      ((size == SIZE_WORD) && (addr_lo != 2'd0));

    always_comb begin
        w_byte = load_data[7:0];
        case (addr_lo)
            2'd0:    w_byte = load_data[7:0];
            2'd1:    w_byte = load_data[15:8];
            2'd2:    w_byte = load_data[23:16];
            default: w_byte = load_data[31:24];
        endcase
    end

    assign w_half = addr_lo[1] ? load_data[31:16] : load_data[15:0];

    always_comb begin
        wstrb       = 4'b1111;
        wdata       = store_data;
        load_result = load_data;
        case (size)
            SIZE_BYTE: begin
                wstrb       = 4'b0001 << addr_lo;
                wdata       = {4{store_data[7:0]}};
                load_result = {{(GRLEN-8){w_sext & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                wstrb       = 4'b0011 << addr_lo;
                wdata       = {2{store_data[15:0]}};
                load_result = {{(GRLEN-16){w_sext & w_half[15]}}, w_half};
            end
            default: begin
                wstrb       = 4'b1111;
                wdata       = store_data;
                load_result = load_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu7_lsu_ctl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu7_lsu_ctl : load/store control stage driving an SRAM-like bus with |
// |                a one-cycle completion pulse towards writeback         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu7_lsu_ctl
    import cpu7_lsu_ctl_pkg::*;
#(
    parameter int GRLEN        = 32,
    parameter int LSU_CODE_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecl_lsu_valid_e,
    input  logic [LSU_CODE_BIT-1:0] ecl_lsu_op_e,
    input  logic [GRLEN-1:0]        ecl_lsu_base_e,
    input  logic [GRLEN-1:0]        ecl_lsu_offset_e,
    input  logic [GRLEN-1:0]        ecl_lsu_wdata_e,
    input  logic [4:0]              ecl_lsu_rd_e,
    input  logic                    ecl_lsu_wen_e,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [GRLEN-1:0]        data_addr,
    output logic [3:0]              data_wstrb,
    output logic [GRLEN-1:0]        data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [GRLEN-1:0]        data_rdata,
    output logic [GRLEN-1:0]        lsu_ecl_rdata_m,
    output logic                    lsu_ecl_rdata_valid_m,
    output logic [4:0]              lsu_ecl_rd_m,
    output logic                    lsu_ecl_wen_m,
    output logic                    lsu_ecl_ale_m
);

    lsu_state_t              r_state;
    logic [LSU_CODE_BIT-1:0] r_op;
    logic [4:0]              r_rd;
    logic                    r_wen;

    logic                    w_idle;
    logic [GRLEN-1:0]        w_addr_e;
    logic [LSU_CODE_BIT-1:0] w_align_op;
    logic [1:0]              w_align_lo;
    logic [1:0]              w_size;
    logic                    w_is_store;
    logic                    w_misalign;
    logic [3:0]              w_wstrb;
    logic [GRLEN-1:0]        w_wdata;
    logic [GRLEN-1:0]        w_load_result;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_addr_e = ecl_lsu_base_e + ecl_lsu_offset_e;

    // One aligner serves both phases: E-stage fields while idle, latched op/address afterwards.
    assign w_align_op = w_idle ? ecl_lsu_op_e   : r_op;
    assign w_align_lo = w_idle ? w_addr_e[1:0]  : data_addr[1:0];

    cpu7_lsu_align #(
        .GRLEN        (GRLEN),
        .LSU_CODE_BIT (LSU_CODE_BIT)
    ) u_align (
        .op          (w_align_op),
        .addr_lo     (w_align_lo),
        .store_data  (ecl_lsu_wdata_e),
        .load_data   (data_rdata),
        .size        (w_size),
        .is_store    (w_is_store),
        .misalign    (w_misalign),
        .wstrb       (w_wstrb),
        .wdata       (w_wdata),
        .load_result (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_op                  <= '0;
            r_rd                  <= '0;
            r_wen                 <= 1'b0;
            data_req              <= 1'b0;
            data_wr               <= 1'b0;
            data_size             <= '0;
            data_addr             <= '0;
            data_wstrb            <= '0;
            data_wdata            <= '0;
            lsu_ecl_rdata_m       <= '0;
            lsu_ecl_rdata_valid_m <= 1'b0;
            lsu_ecl_rd_m          <= '0;
            lsu_ecl_wen_m         <= 1'b0;
            lsu_ecl_ale_m         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ecl_lsu_valid_e) begin
                        r_op  <= ecl_lsu_op_e;
                        r_rd  <= ecl_lsu_rd_e;
                        r_wen <= ecl_lsu_wen_e;
                        if (w_misalign) begin
                            r_state               <= ST_DONE;
                            lsu_ecl_rdata_valid_m <= 1'b1;
                            lsu_ecl_rd_m          <= ecl_lsu_rd_e;
                            lsu_ecl_wen_m         <= 1'b0;
                            lsu_ecl_ale_m         <= 1'b1;
                            lsu_ecl_rdata_m       <= '0;
                        end else begin
                            r_state    <= ST_REQ;
                            data_req   <= 1'b1;
                            data_wr    <= w_is_store;
                            data_size  <= w_size;
                            data_addr  <= w_addr_e;
                            data_wstrb <= w_wstrb;
                            data_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            r_state               <= ST_DONE;
                            lsu_ecl_rdata_valid_m <= 1'b1;
                            lsu_ecl_rd_m          <= r_rd;
                            lsu_ecl_wen_m         <= r_wen & ~w_is_store;
                            lsu_ecl_ale_m         <= 1'b0;
                            lsu_ecl_rdata_m       <= w_is_store ? '0 : w_load_result;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        r_state               <= ST_DONE;
                        lsu_ecl_rdata_valid_m <= 1'b1;
                        lsu_ecl_rd_m          <= r_rd;
                        lsu_ecl_wen_m         <= r_wen & ~w_is_store;
                        lsu_ecl_ale_m         <= 1'b0;
                        lsu_ecl_rdata_m       <= w_is_store ? '0 : w_load_result;
                    end
                end
                ST_DONE: begin
                    r_state               <= ST_IDLE;
                    lsu_ecl_rdata_valid_m <= 1'b0;
                    lsu_ecl_rd_m          <= '0;
                    lsu_ecl_wen_m         <= 1'b0;
                    lsu_ecl_ale_m         <= 1'b0;
                    lsu_ecl_rdata_m       <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The front end must hold off new ops while an access is in flight.
    a_no_valid_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(ecl_lsu_valid_e && (r_state != ST_IDLE))
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu7_lsu_ctl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cpu7_lsu_ctl : directed and randomized checks of cpu7_lsu_ctl      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_cpu7_lsu_ctl;

    localparam logic [3:0] OP_LB = 4'd0, OP_LH = 4'd1, OP_LW = 4'd2, OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5, OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e;
    logic [3:0]  op_e;
    logic [31:0] base_e, offset_e, wdata_e;
    logic [4:0]  rd_e;
    logic        wen_e;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata_m;
    logic        rvalid_m, wen_m, ale_m;
    logic [4:0]  rd_m;

    int checks = 0;
    int errors = 0;
    logic        stray_en = 1'b0;
    logic [31:0] last_rdata;
    logic [31:0] mem [int unsigned];

    cpu7_lsu_ctl #(.GRLEN(32), .LSU_CODE_BIT(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ecl_lsu_valid_e       (valid_e),
        .ecl_lsu_op_e          (op_e),
        .ecl_lsu_base_e        (base_e),
        .ecl_lsu_offset_e      (offset_e),
        .ecl_lsu_wdata_e       (wdata_e),
        .ecl_lsu_rd_e          (rd_e),
        .ecl_lsu_wen_e         (wen_e),
        .data_req              (data_req),
        .data_wr               (data_wr),
        .data_size             (data_size),
        .data_addr             (data_addr),
        .data_wstrb            (data_wstrb),
        .data_wdata            (data_wdata),
        .data_addr_ok          (data_addr_ok),
        .data_data_ok          (data_data_ok),
        .data_rdata            (data_rdata),
        .lsu_ecl_rdata_m       (rdata_m),
        .lsu_ecl_rdata_valid_m (rvalid_m),
        .lsu_ecl_rd_m          (rd_m),
        .lsu_ecl_wen_m         (wen_m),
        .lsu_ecl_ale_m         (ale_m)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return !(op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        if (!mem.exists(idx)) mem[idx] = $urandom;
        return mem[idx];
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] word);
        int nb = op_bytes(op);
        logic [31:0] raw, mask;
        if (nb == 4) return word;
        raw  = word >> (8 * addr[1:0]);
        mask = (32'd1 << (8 * nb)) - 32'd1;
        raw  = raw & mask;
        if ((op == OP_LB || op == OP_LH) && raw[8*nb-1]) raw = raw | ~mask;
        return raw;
    endfunction

    function automatic logic [3:0] model_strb(input int nb, input logic [31:0] addr);
        return 4'(((1 << nb) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] d);
        if (nb == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic mem_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d);
        logic [31:0] w = mem_read(addr);
        for (int b = 0; b < 4; b++)
            if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[addr >> 2] = w;
    endtask

    // One complete transaction; called in an IDLE cycle at posedge+1.
    task automatic do_op(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd, input logic wen,
                         input int aok_dly, input int dok_dly);
        logic [31:0] addr, word, exp_res;
        int nb;
        logic mis, ld;
        addr    = base + off;
        nb      = op_bytes(op);
        mis     = (addr % nb) != 0;
        ld      = op_is_load(op);
        word    = mem_read(addr);
        exp_res = (ld && !mis) ? model_load(op, addr, word) : 32'd0;

        valid_e = 1'b1; op_e = op; base_e = base; offset_e = off;
        wdata_e = wd; rd_e = rd; wen_e = wen;
        tick();
        valid_e = 1'b0; op_e = 4'($urandom); base_e = $urandom; offset_e = $urandom;
        wdata_e = $urandom; rd_e = 5'($urandom); wen_e = 1'($urandom);

        if (mis) begin
            check("misalign_no_req", {31'd0, data_req}, 32'd0);
        end else begin
            for (int k = 0; k <= aok_dly; k++) begin
                check("req_high", {31'd0, data_req}, 32'd1);
                check("req_addr", data_addr, addr);
                check("no_early_pulse", {31'd0, rvalid_m}, 32'd0);
                if (k == 0) begin
                    check("req_size", {30'd0, data_size}, (nb == 1) ? 32'd0 : (nb == 2) ? 32'd1 : 32'd2);
                    check("req_wr", {31'd0, data_wr}, {31'd0, !ld});
                    if (!ld) begin
                        check("req_wstrb", {28'd0, data_wstrb}, {28'd0, model_strb(nb, addr)});
                        check("req_wdata", data_wdata, model_wdata(nb, wd));
                    end
                end
                data_ok_drive(stray_en && (k < aok_dly));
                if (k == aok_dly) begin
                    data_addr_ok = 1'b1;
                    if (dok_dly == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = ld ? word : $urandom;
                    end
                end
                tick();
                data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
            end
            for (int d = 1; d <= dok_dly; d++) begin
                check("req_dropped", {31'd0, data_req}, 32'd0);
                check("no_early_pulse", {31'd0, rvalid_m}, 32'd0);
                data_addr_ok = stray_en && (d < dok_dly) && 1'($urandom);
                if (d == dok_dly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = ld ? word : $urandom;
                end
                tick();
                data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
            end
        end

        check("pulse", {31'd0, rvalid_m}, 32'd1);
        check("pulse_ale", {31'd0, ale_m}, {31'd0, mis});
        check("pulse_wen", {31'd0, wen_m}, {31'd0, wen && ld && !mis});
        check("pulse_rd", {27'd0, rd_m}, {27'd0, rd});
        check("pulse_rdata", rdata_m, exp_res);
        check("done_no_req", {31'd0, data_req}, 32'd0);
        last_rdata = rdata_m;
        if (!ld && !mis) mem_write(addr, model_strb(nb, addr), model_wdata(nb, wd));
        tick();
        check("post_pulse", {31'd0, rvalid_m}, 32'd0);
        check("post_hold", {rdata_m[31:7], rd_m, wen_m, ale_m}, 32'd0);
    endtask

    task automatic data_ok_drive(input logic en);
        data_data_ok = en && 1'($urandom);
    endtask

    initial begin
        logic [3:0] ops [8];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        rst = 1'b1; valid_e = 1'b0; op_e = '0; base_e = '0; offset_e = '0;
        wdata_e = '0; rd_e = '0; wen_e = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_req", {31'd0, data_req}, 32'd0);
        check("reset_addr", data_addr, 32'd0);
        check("reset_outs", {rdata_m[31:8], rvalid_m, rd_m, wen_m, ale_m}, 32'd0);
        tick();

        mem[32'h1004 >> 2] = 32'hDEAD_BEEF;
        do_op(OP_LW, 32'h1000, 32'h4, 32'h0, 5'd7, 1'b1, 0, 1);
        check("t1_lw", last_rdata, 32'hDEAD_BEEF);

        mem[32'h2000 >> 2] = 32'h8011_2233;
        do_op(OP_LB, 32'h2000, 32'h3, 32'h0, 5'd3, 1'b1, 0, 1);
        check("t2_lb", last_rdata, 32'hFFFF_FF80);
        do_op(OP_LBU, 32'h2001, 32'h2, 32'h0, 5'd4, 1'b1, 0, 0);
        check("t2_lbu", last_rdata, 32'h0000_0080);
        do_op(OP_LHU, 32'h2002, 32'h0, 32'h0, 5'd5, 1'b1, 1, 2);
        check("t2_lhu", last_rdata, 32'h0000_8011);

        do_op(OP_SH, 32'h3000, 32'h2, 32'h1234_ABCD, 5'd6, 1'b1, 0, 1);
        do_op(OP_LW, 32'h4000, 32'h2, 32'h0, 5'd8, 1'b1, 0, 1);
        do_op(OP_LW, 32'h5000, 32'h8, 32'h0, 5'd9, 1'b1, 5, 3);

        // Reset while waiting for read data, then a stray data_ok.
        valid_e = 1'b1; op_e = OP_LW; base_e = 32'h6000; offset_e = 32'h0; rd_e = 5'd10; wen_e = 1'b1;
        tick();
        valid_e = 1'b0;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("wait_req_low", {31'd0, data_req}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req", {31'd0, data_req}, 32'd0);
        check("rst_mid_addr", data_addr, 32'd0);
        check("rst_mid_outs", {rdata_m[31:8], rvalid_m, rd_m, wen_m, ale_m}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_pulse", {31'd0, rvalid_m}, 32'd0);
            tick();
        end
        mem[32'h6000 >> 2] = 32'h1357_9BDF;
        do_op(OP_LW, 32'h6000, 32'h0, 32'h0, 5'd11, 1'b1, 0, 1);
        check("t6_lw", last_rdata, 32'h1357_9BDF);

        stray_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] b, o;
            data_addr_ok = 1'($urandom);
            data_data_ok = 1'($urandom);
            tick();
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            check("idle_stray", {30'd0, rvalid_m, data_req}, 32'd0);
            if ((n % 10) == 9) begin
                b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                o = 32'h20;
            end else begin
                b = 32'h7000 + 32'($urandom_range(0, 31));
                o = 32'($urandom_range(0, 15));
            end
            do_op(ops[$urandom_range(0, 7)], b, o, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
